// File: rtl/uart_nibble_tx.sv
// -----------------------------------------------------------------------------
// uart_nibble_tx
//
// UART transmitter for short (default 4-bit) frames: one start bit (0),
// DATA_BITS data bits LSB first, one stop bit (1); the line idles high.
// Nibbles arrive over a valid/ready interface into a small FIFO and are
// serialised back-to-back, with no idle gap between queued frames.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   in_data     nibble to send (sampled only when a push occurs)
//   in_valid    in_data valid
//   in_ready    FIFO can accept (registered, equals !full)
//   tx          serial line, registered
//   busy        high from the first start-bit cycle through the last stop-bit
//               cycle of a frame (stays high across back-to-back frames)
//   frame_sent  one-cycle pulse during the final cycle of each stop bit
//   fifo_count  entries currently buffered
// -----------------------------------------------------------------------------
module uart_nibble_tx #(
  parameter int CLK_FREQ_HZ = 1_600_000,
  parameter int BAUD_RATE   = 100_000,
  parameter int DATA_BITS   = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [DATA_BITS-1:0]                in_data,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic                                tx,
  output logic                                busy,
  output logic                                frame_sent,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CNT_W        = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  generate
    if (CLK_FREQ_HZ % BAUD_RATE != 0) begin : g_bad_ratio
      $error("uart_nibble_tx: CLK_FREQ_HZ must be an integer multiple of BAUD_RATE");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
      $error("uart_nibble_tx: CLKS_PER_BIT must be at least 2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("uart_nibble_tx: FIFO_DEPTH must be a power of two and at least 2");
    end
    if (DATA_BITS < 1) begin : g_bad_width
      $error("uart_nibble_tx: DATA_BITS must be at least 1");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 full_q, full_d;
  logic                 push;
  logic                 pop;
  logic [DATA_BITS-1:0] head;

  // in_ready comes straight from a flop, so a pop on this edge cannot open
  // the FIFO to a push on the same edge.
  assign push = in_valid && !full_q;

  // The head is read combinationally so a pop can load the shift register on
  // the same edge that the FSM leaves IDLE/STOP; the FIFO is only a handful
  // of entries, so this maps onto distributed RAM / registers.
  assign head = fifo_mem[rd_ptr_q];

  // Storage is intentionally not reset: emptiness is tracked by the count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= in_data;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d = (count_d == CNT_W'(FIFO_DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [BAUD_W-1:0]    baud_cnt_q, baud_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] shift_next;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 baud_last;
  logic                 fifo_nonempty;

  assign baud_last     = (baud_cnt_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign fifo_nonempty = (count_q != '0);
  assign shift_next    = shift_q >> 1;

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    pop        = 1'b0;
    frame_sent = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (fifo_nonempty) begin
          pop        = 1'b1;
          shift_d    = head;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = START;
        end
      end

      START: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          tx_d       = shift_q[0];
          state_d    = DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            // tx is registered, so the next bit is taken from the shifted value
            shift_d   = shift_next;
            tx_d      = shift_next[0];
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end

      STOP: begin
        if (baud_last) begin
          frame_sent = 1'b1;
          baud_cnt_d = '0;
          if (fifo_nonempty) begin
            // Chain straight into the next start bit; busy stays high.
            pop       = 1'b1;
            shift_d   = head;
            tx_d      = 1'b0;
            bit_cnt_d = '0;
            state_d   = START;
          end else begin
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end

      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign in_ready   = !full_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_nibble_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_nibble_tx
//
// Self-checking bench for uart_nibble_tx. Instance a uses default parameters
// (16 clocks/bit); instance b uses 1 MHz / 125 kbaud (8 clocks/bit).
// A bench-side receiver decodes the line of instance a mid-bit so queued
// sequences can be checked for content and order.
// -----------------------------------------------------------------------------
module tb_uart_nibble_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in_data_a, in_data_b;
  logic       in_valid_a, in_valid_b;
  logic       in_ready_a, in_ready_b;
  logic       tx_a, tx_b;
  logic       busy_a, busy_b;
  logic       fs_a, fs_b;
  logic [2:0] cnt_a, cnt_b;

  always #5 clk = ~clk;

  uart_nibble_tx dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data_a),
    .in_valid   (in_valid_a),
    .in_ready   (in_ready_a),
    .tx         (tx_a),
    .busy       (busy_a),
    .frame_sent (fs_a),
    .fifo_count (cnt_a)
  );

  uart_nibble_tx #(
    .CLK_FREQ_HZ (1_000_000),
    .BAUD_RATE   (125_000)
  ) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data_b),
    .in_valid   (in_valid_b),
    .in_ready   (in_ready_b),
    .tx         (tx_b),
    .busy       (busy_b),
    .frame_sent (fs_b),
    .fifo_count (cnt_b)
  );

  int checks = 0;
  int errors = 0;

  // Selects which instance the push/frame tasks talk to.
  int   which = 0;
  logic cur_tx, cur_busy, cur_fs, cur_ready;
  always_comb begin
    cur_tx    = (which == 0) ? tx_a       : tx_b;
    cur_busy  = (which == 0) ? busy_a     : busy_b;
    cur_fs    = (which == 0) ? fs_a       : fs_b;
    cur_ready = (which == 0) ? in_ready_a : in_ready_b;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // frame_sent bookkeeping for instance a
  int cyc = 0;
  int fs_cnt = 0;
  int fs_last = 0;
  int fs_prev = 0;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (fs_a === 1'b1) begin
      fs_cnt  <= fs_cnt + 1;
      fs_prev <= fs_last;
      fs_last <= cyc;
    end
  end

  // Bench receiver for instance a: detect the falling edge of the start bit,
  // then sample the centre of every bit (16 clocks/bit).
  logic [3:0] rx_q[$];
  int         rx_stop_err = 0;
  logic [3:0] mon_d;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx_a === 1'b0) begin
        repeat (8) @(negedge clk);
        if (tx_a === 1'b0) begin
          for (int i = 0; i < 4; i++) begin
            repeat (16) @(negedge clk);
            mon_d[i] = tx_a;
          end
          repeat (16) @(negedge clk);
          if (tx_a !== 1'b1) rx_stop_err++;
          rx_q.push_back(mon_d);
        end
      end
    end
  end

  // Present d on the selected instance until accepted (bounded).
  task automatic push(input logic [3:0] d);
    int n;
    n = 0;
    if (which == 0) begin in_data_a = d; in_valid_a = 1'b1; end
    else            begin in_data_b = d; in_valid_b = 1'b1; end
    while (cur_ready !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("push in_ready", cur_ready, 1);
    @(negedge clk);
    if (which == 0) in_valid_a = 1'b0;
    else            in_valid_b = 1'b0;
  endtask

  // Wait for a start bit, then check every cycle of the frame against the
  // expected symbol pattern (bit 0 = start ... bit 5 = stop), that busy is
  // high throughout and that frame_sent fires only in the last stop cycle.
  task automatic frame_check(input logic [5:0] exp, input int cpb, input string name);
    int   n;
    logic sym_ok;
    logic fs_ok;
    n = 0;
    while (cur_tx !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({name, " start seen"}, (n < 400), 1);
    fs_ok = 1'b1;
    for (int s = 0; s < 6; s++) begin
      sym_ok = 1'b1;
      for (int c = 0; c < cpb; c++) begin
        if (cur_tx !== exp[s] || cur_busy !== 1'b1) sym_ok = 1'b0;
        if (cur_fs !== ((s == 5) && (c == cpb - 1))) fs_ok = 1'b0;
        @(negedge clk);
      end
      check($sformatf("%s sym%0d", name, s), sym_ok, 1);
    end
    check({name, " frame_sent timing"}, fs_ok, 1);
  endtask

  typedef struct {
    logic [3:0] data;
    logic [5:0] line;   // expected line symbols, [0]=start ... [5]=stop
    string      name;
  } vec_t;

  vec_t vecs[6];

  logic [3:0] loop_seq[10];
  int         n;
  int         err0;
  int         fs0;
  logic       idle_ok;

  initial begin
    vecs[0] = '{4'b0000, 6'b100000, "v0000"};
    vecs[1] = '{4'b1111, 6'b111110, "v1111"};
    vecs[2] = '{4'b1010, 6'b110100, "v1010"};
    vecs[3] = '{4'b0101, 6'b101010, "v0101"};
    vecs[4] = '{4'b1000, 6'b110000, "v1000"};
    vecs[5] = '{4'b0011, 6'b100110, "v0011"};
    loop_seq = '{4'd1, 4'd0, 4'd0, 4'd4, 4'd1, 4'd9, 4'd1, 4'd4, 4'd3, 4'd6};

    rst_n = 1'b0;
    in_data_a = '0; in_valid_a = 1'b0;
    in_data_b = '0; in_valid_b = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("reset tx", tx_a, 1);
    check("reset busy", busy_a, 0);
    check("reset frame_sent", fs_a, 0);
    check("reset fifo_count", cnt_a, 0);
    check("reset in_ready", in_ready_a, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Single frame with latency: push at E0, tx falls at E1
    which = 0;
    in_data_a = 4'b0001; in_valid_a = 1'b1;
    @(negedge clk);
    in_valid_a = 1'b0;
    in_data_a  = 4'hF;          // must not affect the queued frame
    check("lat E0 count", cnt_a, 1);
    check("lat E0 tx", tx_a, 1);
    @(negedge clk);
    check("lat E1 tx", tx_a, 0);
    check("lat E1 count", cnt_a, 0);
    frame_check(6'b100010, 16, "single");
    check("single busy after", busy_a, 0);
    check("single tx after", tx_a, 1);
    $display("single frame 0001 done");

    // Table-driven single frames
    for (int i = 0; i < 6; i++) begin
      push(vecs[i].data);
      frame_check(vecs[i].line, 16, vecs[i].name);
      check({vecs[i].name, " idle after"}, busy_a, 0);
      $display("vector %s data=%b done", vecs[i].name, vecs[i].data);
    end

    // Back-to-back frames
    rx_q.delete();
    push(4'b0110);
    push(4'b1001);
    frame_check(6'b101100, 16, "b2b first");
    check("b2b no gap tx", tx_a, 0);
    check("b2b busy held", busy_a, 1);
    frame_check(6'b110010, 16, "b2b second");
    check("b2b frame_sent spacing", fs_last - fs_prev, 96);
    check("b2b rx count", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      check("b2b rx0", rx_q[0], 4'b0110);
      check("b2b rx1", rx_q[1], 4'b1001);
    end
    $display("back-to-back 0110,1001 done");

    // FIFO full: in_valid held for values 1..6
    rx_q.delete();
    in_data_a = 4'd1; in_valid_a = 1'b1;
    @(negedge clk); check("full E0 count", cnt_a, 1);
    in_data_a = 4'd2;
    @(negedge clk); check("full E1 count", cnt_a, 1); check("full E1 tx", tx_a, 0);
    in_data_a = 4'd3;
    @(negedge clk); check("full E2 count", cnt_a, 2);
    in_data_a = 4'd4;
    @(negedge clk); check("full E3 count", cnt_a, 3);
    in_data_a = 4'd5;
    @(negedge clk); check("full E4 count", cnt_a, 4); check("full E4 in_ready", in_ready_a, 0);
    in_data_a = 4'd6;
    @(negedge clk); check("full E5 count", cnt_a, 4); check("full E5 in_ready", in_ready_a, 0);
    n = 0;
    while (in_ready_a !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("full ready return cycles", n, 92);
    @(negedge clk);
    in_valid_a = 1'b0;
    check("full count after 6th", cnt_a, 4);
    n = 0;
    while (rx_q.size() < 6 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("full rx count", rx_q.size(), 6);
    for (int i = 0; i < 6 && i < rx_q.size(); i++)
      check($sformatf("full rx%0d", i), rx_q[i], i + 1);
    n = 0;
    while (busy_a !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    $display("fifo full sequence done");

    // Loopback-style sequence decoded by the bench receiver
    rx_q.delete();
    err0 = rx_stop_err;
    fs0  = fs_cnt;
    for (int i = 0; i < 10; i++) push(loop_seq[i]);
    n = 0;
    while ((rx_q.size() < 10 || busy_a !== 1'b0) && n < 1500) begin
      @(negedge clk);
      n++;
    end
    check("loop rx count", rx_q.size(), 10);
    for (int i = 0; i < 10 && i < rx_q.size(); i++)
      check($sformatf("loop rx%0d", i), rx_q[i], loop_seq[i]);
    check("loop stop errors", rx_stop_err - err0, 0);
    check("loop frame_sent count", fs_cnt - fs0, 10);
    $display("loop sequence 1004191436 done");

    // Reset mid-frame during data bit 2 with two entries queued
    push(4'b0001);
    push(4'b0010);
    push(4'b0011);
    check("rst queued", cnt_a, 2);
    repeat (54) @(negedge clk);
    check("rst pre tx (bit2=0)", tx_a, 0);
    #2 rst_n = 1'b0;
    #1;
    check("rst async tx", tx_a, 1);
    check("rst async count", cnt_a, 0);
    check("rst async busy", busy_a, 0);
    check("rst async frame_sent", fs_a, 0);
    check("rst async in_ready", in_ready_a, 1);
    @(negedge clk);
    rst_n = 1'b1;
    idle_ok = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || fs_a !== 1'b0 || busy_a !== 1'b0) idle_ok = 1'b0;
    end
    check("rst line stays idle", idle_ok, 1);
    check("rst count stays 0", cnt_a, 0);
    $display("reset mid-frame done");

    // Non-default ratio: 8 clocks/bit, 48-cycle frame
    which = 1;
    push(4'b1010);
    frame_check(6'b110100, 8, "ratio8");
    check("ratio8 idle after 48", busy_b, 0);
    check("ratio8 tx after", tx_b, 1);
    $display("ratio 8 frame 1010 done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_nibble_tx.md
Name: uart_nibble_tx

Overview:
- UART transmitter that produces the 4-bit frames consumed by the existing receiver/ID-matcher path in `top`: 1 start bit (0), DATA_BITS data bits LSB first, 1 stop bit (1). Idle line is 1.
- Sits upstream of the receiver. Used as the on-chip stimulus source and as the loopback driver for board tests.
- Accepts nibbles over a valid/ready interface into a small FIFO and serialises them back-to-back at BAUD_RATE.

Parameters:
- CLK_FREQ_HZ, 1_600_000, system clock frequency.
- BAUD_RATE, 100_000, line bit rate. CLKS_PER_BIT = CLK_FREQ_HZ/BAUD_RATE (default 16).
- DATA_BITS, 4, payload bits per frame.
- FIFO_DEPTH, 4, nibble buffer entries; must be a power of two and at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  DATA_BITS  nibble to send.
- in_valid  in  1  in_data valid.
- in_ready  out  1  FIFO can accept; equals !full.
- tx  out  1  serial line, registered.
- busy  out  1  high while a frame is on the line, from start bit through stop bit.
- frame_sent  out  1  one-cycle pulse at the end of each stop bit.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  entries currently buffered.

Behaviour:
- Elaboration: CLK_FREQ_HZ % BAUD_RATE must equal 0 and CLKS_PER_BIT must be at least 2; otherwise the block raises an elaboration error.
- Reset values (asynchronous, immediate): tx=1, busy=0, frame_sent=0, fifo_count=0, in_ready=1. FSM goes to IDLE, bit and baud counters clear, FIFO pointers clear and contents are discarded.
- Push rule: a push occurs on any edge where in_valid && in_ready. in_ready depends only on the registered full flag, with no combinational path from pop. in_valid while full is not accepted; the producer holds its data.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: tx=1. On the edge where fifo_count!=0, pop the head into the shift register, set tx=0, busy=1, and go to START.
- Latency: when a push occurs at edge E0 into an empty FIFO while IDLE, the pop occurs and tx falls at E1.
- START: hold for CLKS_PER_BIT cycles, then drive data bit 0 and go to DATA.
- DATA: each bit is held exactly CLKS_PER_BIT cycles, LSB first. After bit DATA_BITS-1 completes, set tx=1 and go to STOP.
- STOP: hold for CLKS_PER_BIT cycles. On the final cycle, frame_sent=1 for exactly one cycle.
  - If the FIFO is non-empty at that edge: pop and start the next frame directly, with tx=0 on the next edge and busy staying 1. There is no idle gap.
  - Otherwise go to IDLE with busy=0.
- Frame length: (DATA_BITS+2)*CLKS_PER_BIT = 96 cycles at defaults. Back-to-back frame period is also 96 cycles.
- Simultaneous push and pop on one edge: both take effect and fifo_count is unchanged. If the FIFO is full, the push does not occur because in_ready is low, so the pop frees one slot from the next cycle.
- Pointer wrap: pointers are width $clog2(FIFO_DEPTH) and wrap naturally. fifo_count is the separate up/down counter; full = (fifo_count==FIFO_DEPTH).
- Reset mid-frame: tx returns to 1 asynchronously and the partial frame is abandoned. The receiver sees a truncated frame; that is acceptable.
- in_data is sampled only at push. Later changes to in_data do not affect queued or in-flight frames.

Test Plan:
1. Single frame: after reset, push 4'b0001 once. Required: tx=0 for 16 cycles, then 1,0,0,0 for 16 cycles each, then 1 for 16 cycles. frame_sent pulses once, 96 cycles after tx falls. busy is high for exactly 96 cycles.
2. Back-to-back: push 4'b0110 and 4'b1001 on consecutive cycles. Required: second start bit begins the cycle after the first stop bit ends. frame_sent pulses 96 cycles apart. busy never drops between frames.
3. FIFO full: from idle, hold in_valid=1 for 6 consecutive cycles with values 1..6.
   - Required: 5 accepted (first popped at E1), fifo_count=4 after E4, in_ready=0 at E5.
   - in_ready returns to 1 the cycle after the second pop, about 96 cycles later.
   - All 6 nibbles are transmitted in order.
4. Loopback: connect tx to `top` rx (ID_LAST_DIGIT=6) and push the sequence 1,0,0,4,1,9,1,4,3,6. Required: 10 frame_done pulses, framing_error never asserted, match asserted after the final 6.
5. Reset mid-frame: assert rst_n=0 during data bit 2 with 2 entries queued. Required: tx=1 immediately, fifo_count=0, no frame_sent. After release, the line stays idle until a new push arrives.
6. Non-default ratio: CLK_FREQ_HZ=1_000_000, BAUD_RATE=125_000. Required: 8 cycles per bit and a 48-cycle frame for nibble 4'b1010.
